// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

    // Upper bound on requester index width; NUM_REQ may go up to 2**IDX_MAX_W.
    localparam int IDX_MAX_W = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [IDX_MAX_W-1:0] rr_ptr;
        logic                 locked;
        logic [IDX_MAX_W-1:0] lock_id;
    } arb_state_t;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Rotate so ptr is bit 0, priority-encode the lowest bit, then rotate the index back.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    assign rot = N'({req, req} >> ptr);

    always_comb begin
        off     = '0;
        gnt_vld = |rot;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (W+1)'(N)) begin
            gnt_idx = W'(sum - (W+1)'(N));
        end else begin
            gnt_idx = W'(sum);
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 stream arbiter with optional packet lock into one registered output stage.
// Latency 1 cycle; full throughput; stalled output drops every in_ready.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 32,
    parameter bit LOCK_ON_LAST = 1'b1,
    localparam int IDW         = clog2_min1(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       in_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] in_data_i,
    input  logic [NUM_REQ-1:0]       in_last_i,
    output logic [NUM_REQ-1:0]       in_ready_o,
    output logic                     out_valid_o,
    output logic [WIDTH-1:0]         out_data_o,
    output logic                     out_last_o,
    output logic [IDW-1:0]           out_id_o,
    input  logic                     out_ready_i
);

    arb_state_t         st_q, st_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [IDW-1:0]     out_id_q, out_id_d;

    logic               accept;
    logic [NUM_REQ-1:0] elig;
    logic               gnt_vld;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     rr_nxt;
    logic               xfer;
    logic               last_g;
    logic               unused_st_bits;

    assign accept = ~out_valid_q | out_ready_i;
    assign elig   = st_q.locked ? (in_valid_i & (NUM_REQ'(1) << st_q.lock_id[IDW-1:0]))
                                : in_valid_i;

    rr_pick #(
        .N (NUM_REQ),
        .W (IDW)
    ) u_pick (
        .req     (elig),
        .ptr     (st_q.rr_ptr[IDW-1:0]),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Ready is forced low while reset is asserted so nothing is handshaken into a register in reset.
    assign xfer       = rst_n & accept & gnt_vld;
    assign in_ready_o = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign last_g     = in_last_i[gnt_idx];
    assign rr_nxt     = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    assign unused_st_bits = ^{st_q.rr_ptr, st_q.lock_id};

    always_comb begin
        st_d        = st_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i[gnt_idx*WIDTH +: WIDTH];
            out_last_d  = last_g;
            out_id_d    = gnt_idx;
            if (LOCK_ON_LAST && !last_g) begin
                st_d.locked  = 1'b1;
                st_d.lock_id = IDX_MAX_W'(gnt_idx);
            end else begin
                st_d.locked  = 1'b0;
                st_d.rr_ptr  = IDX_MAX_W'(rr_nxt);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            st_q        <= st_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench: 4-requester locking arbiter plus a 1-requester non-locking instance.
module tb_stream_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, in_last, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_last, out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;

    logic         s_valid, s_last, s_rdy, s_ov, s_ol, s_ordy;
    logic [7:0]   s_data, s_od;
    logic [0:0]   s_oid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_REQ(4), .WIDTH(32), .LOCK_ON_LAST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_id_o(out_id), .out_ready_i(out_ready)
    );

    stream_rr_arbiter #(.NUM_REQ(1), .WIDTH(8), .LOCK_ON_LAST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s_valid), .in_data_i(s_data), .in_last_i(s_last), .in_ready_o(s_rdy),
        .out_valid_o(s_ov), .out_data_o(s_od), .out_last_o(s_ol),
        .out_id_o(s_oid), .out_ready_i(s_ordy)
    );

    typedef struct {
        logic [3:0] vld;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_id;
        logic       exp_ol;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] mkdata(input int i, input int r);
        return 32'hA000_0000 | 32'(r << 8) | 32'(i);
    endfunction

    function automatic int enc(input logic [3:0] oh);
        int idx = 0;
        for (int k = 0; k < 4; k++) if (oh[k]) idx = k;
        return idx;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int r);
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = mkdata(i, r);
    endtask

    initial begin
        logic [31:0] exp_data;
        // vld, last, ordy, exp_rdy, exp_ov, exp_id, exp_ol
        tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[5]  = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[6]  = '{4'b0111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[7]  = '{4'b0111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[8]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[9]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[10] = '{4'b0111, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[11] = '{4'b1011, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[12] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[13] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[14] = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[15] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[16] = '{4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[17] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};

        rst_n = 1'b0;
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1; set_data(0);
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_ordy = 1'b1;
        exp_data = 32'h0;

        #2;
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_id", out_id, 2'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_s_out_valid", s_ov, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 18; r++) begin
            in_valid = tbl[r].vld; in_last = tbl[r].last; out_ready = tbl[r].ordy; set_data(r);
            #1;
            chk($sformatf("row%0d_in_ready", r), in_ready, tbl[r].exp_rdy);
            if (tbl[r].exp_rdy != 4'b0000) exp_data = mkdata(enc(tbl[r].exp_rdy), r);
            @(posedge clk); #1;
            chk($sformatf("row%0d_out_valid", r), out_valid, tbl[r].exp_ov);
            chk($sformatf("row%0d_out_id", r), out_id, tbl[r].exp_id);
            chk($sformatf("row%0d_out_last", r), out_last, tbl[r].exp_ol);
            chk($sformatf("row%0d_out_data", r), out_data, exp_data);
            @(negedge clk);
        end

        // Backpressure: hold the beat for 5 cycles, then pop and push with no bubble.
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b0; set_data(100);
        #1 chk("bp_first_rdy", in_ready, 4'b0010);
        @(posedge clk); #1;
        chk("bp_first_id", out_id, 2'd1);
        chk("bp_first_data", out_data, mkdata(1, 100));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); set_data(101 + c);
            #1 chk("bp_stall_rdy", in_ready, 4'b0000);
            @(posedge clk); #1;
            chk("bp_stall_valid", out_valid, 1'b1);
            chk("bp_stall_data", out_data, mkdata(1, 100));
        end
        @(negedge clk); out_ready = 1'b1;
        #1 chk("bp_release_rdy", in_ready, 4'b0100);
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 1'b1);
        chk("bp_release_id", out_id, 2'd2);
        chk("bp_release_data", out_data, mkdata(2, 105));

        // Reset in the middle of a locked packet from requester 1.
        @(negedge clk);
        in_valid = 4'b0010; in_last = 4'b0000; out_ready = 1'b1; set_data(110);
        #1 chk("mid_lock_rdy", in_ready, 4'b0010);
        @(posedge clk); #1;
        chk("mid_lock_id", out_id, 2'd1);
        chk("mid_lock_last", out_last, 1'b0);
        @(negedge clk);
        in_valid = 4'b0011; out_ready = 1'b0;
        #1 chk("mid_stall_rdy", in_ready, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_rdy", in_ready, 4'b0000);
        chk("mid_rst_id", out_id, 2'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("post_rst_rdy", in_ready, 4'b0001);
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_id", out_id, 2'd0);
        chk("post_rst_data", out_data, mkdata(0, 110));

        // Single requester, no lock: back-to-back beats at one per cycle.
        @(negedge clk);
        in_valid = 4'b0000;
        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0; s_ordy = 1'b1;
        #1 chk("n1_rdy0", s_rdy, 1'b1);
        @(posedge clk); #1;
        chk("n1_valid0", s_ov, 1'b1);
        chk("n1_data0", s_od, 8'hA5);
        chk("n1_last0", s_ol, 1'b0);
        chk("n1_id0", s_oid, 1'b0);
        @(negedge clk);
        s_data = 8'h5A; s_last = 1'b1;
        #1 chk("n1_rdy1", s_rdy, 1'b1);
        @(posedge clk); #1;
        chk("n1_valid1", s_ov, 1'b1);
        chk("n1_data1", s_od, 8'h5A);
        chk("n1_last1", s_ol, 1'b1);
        chk("n1_id1", s_oid, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("n1_drain_valid", s_ov, 1'b0);
        chk("n1_drain_data", s_od, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
